hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL expose the following ports, one per line: name, direction, width, meaning. The clock is clk and the reset is reset; there is one clock, and reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- id_ex_mem_read  input  1  instruction in EX is a load.
- id_ex_write_reg_addr  input  5  destination register of the instruction in EX.
- if_id_instr_rs  input  5  rs field of the instruction in ID.
- if_id_instr_rt  input  5  rt field of the instruction in ID.
- if_id_uses_rt  input  1  ID instruction reads rt as a source.
- if_id_hilo_read  input  1  ID instruction reads HI/LO (mfhi/mflo).
- branch_taken  input  1  ID-stage branch/jump resolved taken.
- mdu_start  input  1  ID instruction is mult/div.
- mdu_done  input  1  multi-cycle MDU result written to HI/LO.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register enable.
- id_ex_bubble  output  1  zero the ID/EX control bits.
- if_id_flush  output  1  clear the IF/ID instruction.
- mdu_go  output  1  one-cycle launch pulse to the MDU.
- state  output  2  FSM state: 00 = RUN, 01 = MDU_BUSY.
- stall_cycles  output  16  stall-cycle counter.

Function
REQ-002 The block SHALL define load_use = id_ex_mem_read & (id_ex_write_reg_addr != 0) & ((id_ex_write_reg_addr == if_id_instr_rs) | (if_id_uses_rt & (id_ex_write_reg_addr == if_id_instr_rt))).
REQ-003 The block SHALL define mdu_hold = (state == MDU_BUSY) & ~mdu_done & (if_id_hilo_read | mdu_start).
REQ-004 The block SHALL define stall = load_use | mdu_hold.
REQ-005 When stall = 1, the block SHALL drive pc_write = 0, if_id_write = 0, id_ex_bubble = 1, if_id_flush = 0 and mdu_go = 0, all combinationally in the same cycle.
REQ-006 When stall = 0, the block SHALL drive pc_write = 1, if_id_write = 1 and id_ex_bubble = 0.
REQ-007 When stall = 0, the block SHALL drive if_id_flush = branch_taken; a taken branch is ignored during a stall cycle and is re-evaluated when ID is re-presented.
REQ-008 The block SHALL drive mdu_go = mdu_start & ~stall & ~reset.
REQ-009 In state RUN, mdu_go = 1 SHALL cause the next state to be MDU_BUSY; otherwise the FSM SHALL remain in RUN.
REQ-010 In state MDU_BUSY with mdu_done = 1 and mdu_go = 0, the next state SHALL be RUN.
REQ-011 In state MDU_BUSY, instructions that neither read HI/LO nor start the MDU SHALL flow without a stall.
REQ-012 When mdu_done = 1 and mdu_start = 1 arrive in the same MDU_BUSY cycle, the block SHALL treat the unit as free, assert mdu_go (unless load_use is also asserted), and remain in MDU_BUSY.
REQ-013 When load_use = 1 and mdu_done = 1 arrive together in MDU_BUSY, the block SHALL stall and move to RUN.
REQ-014 The block SHALL ignore mdu_done while in RUN.
REQ-015 The load-use stall SHALL last exactly one cycle for a dependent instruction, because the bubble removes the load from EX.
REQ-016 The state register SHALL update only on the rising edge of clk.
REQ-017 Outputs other than state and stall_cycles SHALL be combinational.

Reset
REQ-018 While reset = 1, the block SHALL drive pc_write = 0, if_id_write = 0, id_ex_bubble = 1, if_id_flush = 1 and mdu_go = 0, regardless of other inputs.
REQ-019 On a clk edge with reset = 1, the block SHALL set state to RUN and stall_cycles to 0.
REQ-020 A reset asserted while in MDU_BUSY SHALL abandon the operation; the MDU is reset by the same signal.
REQ-021 In the first cycle after reset deasserts, the block SHALL produce outputs per REQ-005 to REQ-008 from state RUN.

Configuration
REQ-022 The block SHALL compile stall counting in or out with macro HAZARD_STALL_COUNT_EN.
- Defined: stall_cycles increments by 1 on each clk edge where reset = 0 and stall = 1, saturating at 16'hFFFF with no wrap.
- Undefined: stall_cycles is constant 16'h0000 and no counter register is built.
- The port list SHALL be identical in both builds.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Load-use, rs match: id_ex_mem_read = 1, id_ex_write_reg_addr = 5, if_id_instr_rs = 5 -> pc_write = 0, if_id_write = 0, id_ex_bubble = 1 for one cycle; next cycle with id_ex_mem_read = 0 -> pc_write = 1.
- Register $0 and unused rt: id_ex_write_reg_addr = 0 with rs = 0 -> no stall; id_ex_write_reg_addr = 7, rt = 7, if_id_uses_rt = 0 -> no stall.
- MDU sequence: mdu_start = 1 in RUN -> mdu_go = 1, state = 01 next cycle; then if_id_hilo_read = 1 for 4 cycles -> stall for 4 cycles; mdu_done = 1 -> no stall that cycle, state = 00 next cycle.
- Simultaneous events: in MDU_BUSY, mdu_done = 1 and mdu_start = 1 together -> mdu_go = 1, state stays 01; branch_taken = 1 during a load_use stall -> if_id_flush = 0.
- Reset: reset = 1 mid-MDU_BUSY -> state = 00, if_id_flush = 1, id_ex_bubble = 1, mdu_go = 0; with HAZARD_STALL_COUNT_EN, stall_cycles = 0 after reset; counter preloaded near 16'hFFFF saturates at 16'hFFFF; without the macro, stall_cycles stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / HI-LO interlock, branch flush and MDU launch control; HAZARD_STALL_COUNT_EN builds a stall counter.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_write_reg_addr,
  input  logic [4:0]  if_id_instr_rs,
  input  logic [4:0]  if_id_instr_rt,
  input  logic        if_id_uses_rt,
  input  logic        if_id_hilo_read,
  input  logic        branch_taken,
  input  logic        mdu_start,
  input  logic        mdu_done,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        mdu_go,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'b00, MDU_BUSY = 2'b01} state_e;
  state_e state_q, state_d;
  logic load_use, mdu_hold, stall;
  always_comb begin
    load_use = id_ex_mem_read & (id_ex_write_reg_addr != 5'd0) &
               ((id_ex_write_reg_addr == if_id_instr_rs) |
                (if_id_uses_rt & (id_ex_write_reg_addr == if_id_instr_rt)));
    mdu_hold = (state_q == MDU_BUSY) & ~mdu_done & (if_id_hilo_read | mdu_start);
    stall = load_use | mdu_hold;
    pc_write = ~reset & ~stall;
    if_id_write = ~reset & ~stall;
    id_ex_bubble = reset | stall;
    if_id_flush = reset | (~stall & branch_taken);
    mdu_go = mdu_start & ~stall & ~reset;
    // a new launch keeps the unit busy even when the previous result lands this cycle
    state_d = mdu_go ? MDU_BUSY : (state_q == MDU_BUSY && mdu_done) ? RUN : state_q;
  end
  always_ff @(posedge clk) state_q <= reset ? RUN : state_d;
  assign state = state_q;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? 16'd0 : cnt_d;
  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic id_ex_mem_read, if_id_uses_rt, if_id_hilo_read, branch_taken, mdu_start, mdu_done;
  logic [4:0] id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_go;
  logic [1:0] state;
  logic [15:0] stall_cycles;
  int tests = 0, failed = 0;
  bit m_busy = 0;
  int m_cnt = 0;
  bit exp_st, exp_go;
  logic [22:0] exp_o;
  wire [22:0] outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_go, state, stall_cycles};
  wire [4:0] ctrl = {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_go};

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg_addr(id_ex_write_reg_addr),
    .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
    .if_id_uses_rt(if_id_uses_rt), .if_id_hilo_read(if_id_hilo_read),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .mdu_go(mdu_go), .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    bit lu, hold;
    lu = id_ex_mem_read && id_ex_write_reg_addr != 0 &&
         (id_ex_write_reg_addr == if_id_instr_rs ||
          (if_id_uses_rt && id_ex_write_reg_addr == if_id_instr_rt));
    hold = m_busy && !mdu_done && (if_id_hilo_read || mdu_start);
    exp_st = lu || hold;
    exp_go = mdu_start && !exp_st && !reset;
    exp_o = reset ? {5'b00110, 2'(m_busy), 16'(m_cnt)}
                  : {!exp_st, !exp_st, exp_st, !exp_st && branch_taken, exp_go, 2'(m_busy), 16'(m_cnt)};
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reset) m_busy = 0;
    else if (exp_go) m_busy = 1;
    else if (m_busy && mdu_done) m_busy = 0;
`ifdef HAZARD_STALL_COUNT_EN
    if (reset) m_cnt = 0;
    else if (exp_st && m_cnt < 65535) m_cnt++;
`endif
    #1;
  endtask

  task automatic set_in(bit mr, logic [4:0] wa, logic [4:0] rs, logic [4:0] rt, bit ut,
                        bit hilo, bit br, bit st, bit dn);
    id_ex_mem_read = mr; id_ex_write_reg_addr = wa; if_id_instr_rs = rs; if_id_instr_rt = rt;
    if_id_uses_rt = ut; if_id_hilo_read = hilo; branch_taken = br; mdu_start = st; mdu_done = dn;
    #2;
    model_eval();
  endtask

  task automatic do_reset();
    reset = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    set_in(1, 5, 5, 0, 0, 1, 1, 1, 1);
    tick(); tick();
    set_in(1, 5, 5, 0, 0, 1, 1, 1, 1);
    tests++; if (ctrl !== 5'b00110) begin failed++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 5'b00110); end
    tests++; if (state !== 2'b00 || stall_cycles !== 16'h0) begin failed++; $display("FAIL reset_state: got %b/%h want 00/0000", state, stall_cycles); end
    reset = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tests++; if (outs !== exp_o) begin failed++; $display("FAIL first_after_reset: got %h want %h", outs, exp_o); end
    tests++; if (mdu_go !== 1'b1) begin failed++; $display("FAIL first_after_reset_go: got %b want 1", mdu_go); end
    do_reset();
  endtask

  task automatic test_load_use();
    set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
    tests++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001) begin failed++; $display("FAIL load_use_stall: got %b want 001", {pc_write, if_id_write, id_ex_bubble}); end
    tick();
    set_in(0, 5, 5, 0, 0, 0, 0, 0, 0);
    tests++; if (pc_write !== 1'b1 || outs !== exp_o) begin failed++; $display("FAIL load_use_release: got %h want %h", outs, exp_o); end
    tick();
    set_in(1, 9, 3, 9, 1, 0, 0, 0, 0);
    tests++; if (pc_write !== 1'b0) begin failed++; $display("FAIL load_use_rt: got %b want 0", pc_write); end
    tick();
  endtask

  task automatic test_reg0();
    set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
    tests++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin failed++; $display("FAIL reg0_no_stall: got %b%b want 10", pc_write, id_ex_bubble); end
    set_in(1, 7, 2, 7, 0, 0, 0, 0, 0);
    tests++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin failed++; $display("FAIL unused_rt_no_stall: got %b%b want 10", pc_write, id_ex_bubble); end
    tick();
  endtask

  task automatic test_mdu_seq();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tests++; if (mdu_go !== 1'b1 || state !== 2'b00) begin failed++; $display("FAIL mdu_launch: got go=%b st=%b want 1/00", mdu_go, state); end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
      tests++; if (state !== 2'b01 || pc_write !== 1'b0 || outs !== exp_o) begin failed++; $display("FAIL mdu_hilo_stall%0d: got %h want %h", i, outs, exp_o); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    mdu_done = 1; #1;
    tests++; if (pc_write !== 1'b1 || mdu_go !== 1'b0) begin failed++; $display("FAIL mdu_done_release: got %b%b want 10", pc_write, mdu_go); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tests++; if (state !== 2'b00) begin failed++; $display("FAIL mdu_back_run: got %b want 00", state); end
    tests++; if (outs !== exp_o) begin failed++; $display("FAIL done_in_run_ignored: got %h want %h", outs, exp_o); end
    tick();
  endtask

  task automatic test_simultaneous();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tests++; if (mdu_go !== 1'b1 || pc_write !== 1'b1) begin failed++; $display("FAIL done_start_go: got %b%b want 11", mdu_go, pc_write); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (state !== 2'b01) begin failed++; $display("FAIL done_start_busy: got %b want 01", state); end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tests++; if (pc_write !== 1'b1 || if_id_flush !== 1'b1) begin failed++; $display("FAIL busy_flow_branch: got %b%b want 11", pc_write, if_id_flush); end
    set_in(1, 4, 4, 0, 0, 0, 0, 1, 1);
    tests++; if (mdu_go !== 1'b0 || pc_write !== 1'b0) begin failed++; $display("FAIL lu_done_start: got %b%b want 00", mdu_go, pc_write); end
    tick();
    set_in(1, 5, 5, 0, 0, 0, 1, 0, 0);
    tests++; if (state !== 2'b00) begin failed++; $display("FAIL lu_done_to_run: got %b want 00", state); end
    tests++; if (if_id_flush !== 1'b0 || id_ex_bubble !== 1'b1) begin failed++; $display("FAIL branch_in_stall: got %b%b want 01", if_id_flush, id_ex_bubble); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    reset = 1;
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0);
    tests++; if (ctrl !== 5'b00110) begin failed++; $display("FAIL reset_mid_ctrl: got %b want 00110", ctrl); end
    tick();
    reset = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (state !== 2'b00 || stall_cycles !== 16'h0) begin failed++; $display("FAIL reset_mid_state: got %b/%h want 00/0000", state, stall_cycles); end
    tick();
  endtask

  task automatic test_random();
    int nf = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      tests++;
      if (outs !== exp_o) begin
        failed++; nf++;
        if (nf < 10) $display("FAIL random%0d: got %h want %h", i, outs, exp_o);
      end
      tick();
    end
    reset = 0;
  endtask

  task automatic test_counter();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (stall_cycles !== 16'h0) begin failed++; $display("FAIL cnt_after_reset: got %h want 0000", stall_cycles); end
    set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STALL_COUNT_EN
    repeat (65540) tick();
    set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
    tests++; if (stall_cycles !== 16'hFFFF) begin failed++; $display("FAIL cnt_saturate: got %h want ffff", stall_cycles); end
    tick();
    set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
    tests++; if (stall_cycles !== 16'hFFFF) begin failed++; $display("FAIL cnt_no_wrap: got %h want ffff", stall_cycles); end
`else
    repeat (20) tick();
    set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
    tests++; if (stall_cycles !== 16'h0) begin failed++; $display("FAIL cnt_disabled: got %h want 0000", stall_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0();
    test_mdu_seq();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
